// File: rtl/fmul_share_scheduler.sv
// fmul_share_scheduler
// Round-robin scheduler sharing one fixed-latency, non-stallable pipelined FP32
// multiplier among NUM_REQ requesters. One operand pair is issued per cycle and
// tagged with the requester index. The tag rides a MUL_LAT-deep shadow pipe, and
// each result is buffered with its tag in a response FIFO. A credit counter keeps
// issued-but-not-popped work at or below RSP_DEPTH, so the FIFO can never overflow.
//
// Optional feature: define FMUL_SCHED_STATS_EN to add the o_issue_cnt/o_stall_cnt
// 16-bit saturating counters.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid[NUM_REQ]    per-requester request valid
//   i_req_a/i_req_b         packed per-requester operands (requester r at r*DATA_W)
//   o_req_ready[NUM_REQ]    one-hot grant, handshake = valid & ready
//   o_mul_valid/a/b         registered issue to the multiplier
//   i_mul_result            product, valid MUL_LAT cycles after o_mul_valid
//   o_rsp_valid/tag/data    response FIFO head
//   i_rsp_ready             consumer accept, pop = o_rsp_valid & i_rsp_ready
//   o_issue_cnt/o_stall_cnt handshake / credit-stall counters (stats build only)
module fmul_share_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned TAG_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]          o_req_ready,
  output logic                        o_mul_valid,
  output logic [DATA_W-1:0]           o_mul_a,
  output logic [DATA_W-1:0]           o_mul_b,
  input  logic [DATA_W-1:0]           i_mul_result,
  output logic                        o_rsp_valid,
  output logic [TAG_W-1:0]            o_rsp_tag,
  output logic [DATA_W-1:0]           o_rsp_data,
  input  logic                        i_rsp_ready
`ifdef FMUL_SCHED_STATS_EN
  ,
  output logic [15:0]                 o_issue_cnt,
  output logic [15:0]                 o_stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(RSP_DEPTH);

  logic [CNT_W-1:0]  r_cnt;
  logic [TAG_W-1:0]  r_ptr;
  logic              r_mul_valid;
  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;
  logic [TAG_W-1:0]  r_issue_tag;
  logic [MUL_LAT-1:0] r_pipe_vld;
  logic [TAG_W-1:0]  r_pipe_tag [MUL_LAT];
  logic [DATA_W-1:0] r_fifo_data [RSP_DEPTH];
  logic [TAG_W-1:0]  r_fifo_tag [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_fcnt;

  logic              w_credit_ok;
  logic              w_gnt_vld;
  logic [TAG_W-1:0]  w_gnt_idx;
  logic [TAG_W-1:0]  w_idx;
  logic [NUM_REQ-1:0] w_ready;
  logic              w_hs;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;

  // Credit is judged on the registered count only: a pop this cycle frees its
  // credit next cycle, which keeps the grant path short.
  assign w_credit_ok = (r_cnt < LP_DEPTH) && !i_rst;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    w_ready   = '0;
    if (w_credit_ok) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        w_idx = TAG_W'((32'(r_ptr) + k) % NUM_REQ);
        if (!w_gnt_vld && i_req_valid[w_idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_idx;
        end
      end
    end
    if (w_gnt_vld) w_ready[w_gnt_idx] = 1'b1;
  end

  assign o_req_ready = w_ready;
  assign w_hs        = w_gnt_vld;
  assign w_sel_a     = i_req_a[w_gnt_idx*DATA_W +: DATA_W];
  assign w_sel_b     = i_req_b[w_gnt_idx*DATA_W +: DATA_W];

  assign w_push      = r_pipe_vld[MUL_LAT-1];
  assign o_rsp_valid = (r_fcnt != '0);
  assign w_pop       = o_rsp_valid && i_rsp_ready;
  assign w_full      = (r_fcnt == LP_DEPTH);
  assign o_rsp_tag   = r_fifo_tag[r_rptr];
  assign o_rsp_data  = r_fifo_data[r_rptr];

  assign o_mul_valid = r_mul_valid;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_ptr       <= TAG_W'(NUM_REQ - 1);
      r_mul_valid <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_issue_tag <= '0;
      r_pipe_vld  <= '0;
      for (int i = 0; i < int'(MUL_LAT); i++) r_pipe_tag[i] <= '0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_tag[i]  <= '0;
      end
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fcnt      <= '0;
    end else begin
      r_cnt       <= r_cnt + CNT_W'(w_hs) - CNT_W'(w_pop);
      r_mul_valid <= w_hs;
      if (w_hs) begin
        r_ptr       <= w_gnt_idx;
        r_mul_a     <= w_sel_a;
        r_mul_b     <= w_sel_b;
        r_issue_tag <= w_gnt_idx;
      end
      // Shadow pipe aligned so the last stage is valid exactly when the
      // multiplier presents the matching product.
      r_pipe_vld[0] <= r_mul_valid;
      r_pipe_tag[0] <= r_issue_tag;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
      if (w_push) begin
        r_fifo_data[r_wptr] <= i_mul_result;
        r_fifo_tag[r_wptr]  <= r_pipe_tag[MUL_LAT-1];
        r_wptr              <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_fcnt <= r_fcnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

`ifndef SYNTHESIS
  ASSERT_FIFO_NO_OVERFLOW: assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_push && w_full));
`endif

`ifdef FMUL_SCHED_STATS_EN
  logic [15:0] r_issue_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (|i_req_valid) && !(r_cnt < LP_DEPTH) && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_hs && (r_issue_cnt != 16'hFFFF)) r_issue_cnt <= r_issue_cnt + 16'd1;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_issue_cnt = r_issue_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fmul_share_scheduler.sv
module tb_fmul_share_scheduler;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MUL_LAT   = 3;
  localparam int unsigned RSP_DEPTH = 4;
  localparam int unsigned TAG_W     = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_a = '0;
  logic [NUM_REQ*DATA_W-1:0] req_b = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      mul_valid;
  logic [DATA_W-1:0]         mul_a;
  logic [DATA_W-1:0]         mul_b;
  logic [DATA_W-1:0]         mul_result;
  logic                      rsp_valid;
  logic [TAG_W-1:0]          rsp_tag;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_ready = 1'b0;
`ifdef FMUL_SCHED_STATS_EN
  logic [15:0]               issue_cnt;
  logic [15:0]               stall_cnt;
`endif

  always #5 clk = ~clk;

  fmul_share_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_req_ready  (req_ready),
    .o_mul_valid  (mul_valid),
    .o_mul_a      (mul_a),
    .o_mul_b      (mul_b),
    .i_mul_result (mul_result),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_tag    (rsp_tag),
    .o_rsp_data   (rsp_data),
    .i_rsp_ready  (rsp_ready)
`ifdef FMUL_SCHED_STATS_EN
    ,
    .o_issue_cnt  (issue_cnt),
    .o_stall_cnt  (stall_cnt)
`endif
  );

  // FP32 product for normal operands, via double precision (mantissa truncated).
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    logic [63:0] d;
    ra = $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'b0});
    rb = $bitstoreal({b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'b0});
    d  = $realtobits(ra * rb);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] rand_op();
    return {1'($urandom), 8'(120 + $urandom_range(0, 14)), 23'($urandom)};
  endfunction

  // Non-stallable multiplier model; not reset, so late products keep arriving.
  logic [DATA_W-1:0] m_data [MUL_LAT];
  logic              m_vld  [MUL_LAT];
  always @(posedge clk) begin
    m_vld[0]  <= mul_valid;
    m_data[0] <= fmul_model(mul_a, mul_b);
    for (int i = 1; i < int'(MUL_LAT); i++) begin
      m_vld[i]  <= m_vld[i-1];
      m_data[i] <= m_data[i-1];
    end
  end
  assign mul_result = (m_vld[MUL_LAT-1] === 1'b1) ? m_data[MUL_LAT-1] : 32'hDEADBEEF;

  // Reference model: outstanding ops in issue order, each with its due cycle.
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    int                due;
  } op_t;
  op_t q[$];
  int  last_gnt;
  int  cyc;
  logic prev_hs;
  logic [DATA_W-1:0] prev_a, prev_b;
  int  mdl_issue, mdl_stall;

  int n_chk  = 0;
  int n_pass = 0;

  // Observed values of the latest step, for directed checks.
  logic [NUM_REQ-1:0] obs_ready;
  logic               obs_rv;
  logic [TAG_W-1:0]   obs_tag;
  logic [DATA_W-1:0]  obs_data;
  int                 obs_hs;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One cycle: drive inputs, compare outputs against the model, advance.
  task automatic step(input logic [NUM_REQ-1:0] vld, input logic rdy);
    logic [DATA_W-1:0] ta [NUM_REQ];
    logic [DATA_W-1:0] tb [NUM_REQ];
    logic [NUM_REQ-1:0] eg;
    logic found, erv;
    int gi, idx;
    for (int r = 0; r < int'(NUM_REQ); r++) begin
      ta[r] = rand_op();
      tb[r] = rand_op();
      req_a[r*DATA_W +: DATA_W] = ta[r];
      req_b[r*DATA_W +: DATA_W] = tb[r];
    end
    req_valid = vld;
    rsp_ready = rdy;
    #1;
    eg = '0;
    found = 1'b0;
    gi = 0;
    if (q.size() < int'(RSP_DEPTH)) begin
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
        idx = (last_gnt + k) % int'(NUM_REQ);
        if (!found && vld[idx]) begin
          found = 1'b1;
          gi = idx;
        end
      end
    end
    if (found) eg[gi] = 1'b1;
    check_eq("req_ready", 64'(req_ready), 64'(eg));
    check_eq("mul_valid", 64'(mul_valid), 64'(prev_hs));
    if (prev_hs) begin
      check_eq("mul_a", 64'(mul_a), 64'(prev_a));
      check_eq("mul_b", 64'(mul_b), 64'(prev_b));
    end
    erv = (q.size() > 0) && (q[0].due <= cyc);
    check_eq("rsp_valid", 64'(rsp_valid), 64'(erv));
    if (erv) begin
      check_eq("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
      check_eq("rsp_data", 64'(rsp_data), 64'(q[0].data));
    end
    obs_ready = req_ready;
    obs_rv    = rsp_valid;
    obs_tag   = rsp_tag;
    obs_data  = rsp_data;
    if (|(req_ready & vld)) obs_hs++;
    if ((|vld) && q.size() >= int'(RSP_DEPTH)) mdl_stall++;
    if (erv && rdy) void'(q.pop_front());
    prev_hs = found;
    if (found) begin
      prev_a = ta[gi];
      prev_b = tb[gi];
      q.push_back('{tag: TAG_W'(gi), data: fmul_model(ta[gi], tb[gi]),
                    due: cyc + int'(MUL_LAT) + 2});
      last_gnt = gi;
      mdl_issue++;
    end
    @(negedge clk);
    cyc++;
  endtask

  // One reset cycle with all requests valid, then check reset values.
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    #1;
    check_eq("rst_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    check_eq("rst_mul_valid", 64'(mul_valid), 64'(0));
    check_eq("rst_mul_a", 64'(mul_a), 64'(0));
    check_eq("rst_mul_b", 64'(mul_b), 64'(0));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_rsp_tag", 64'(rsp_tag), 64'(0));
    check_eq("rst_rsp_data", 64'(rsp_data), 64'(0));
`ifdef FMUL_SCHED_STATS_EN
    check_eq("rst_issue_cnt", 64'(issue_cnt), 64'(0));
    check_eq("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    q.delete();
    last_gnt  = int'(NUM_REQ) - 1;
    prev_hs   = 1'b0;
    mdl_issue = 0;
    mdl_stall = 0;
  endtask

  initial begin
    int t0, lat, hs0;
    logic [NUM_REQ-1:0] all_v;
    all_v  = '1;
    cyc    = 0;
    obs_hs = 0;
    repeat (2) @(negedge clk);
    do_reset();

    // Single request from requester 1: 1.5 * 2.0.
    req_a[1*DATA_W +: DATA_W] = 32'h3FC00000;
    req_valid = 4'b0010;
    t0 = cyc;
    // Step with fixed operands for this one cycle.
    begin
      req_b[1*DATA_W +: DATA_W] = 32'h40000000;
      rsp_ready = 1'b1;
      #1;
      check_eq("t1_ready", 64'(req_ready), 64'(4'b0010));
      q.push_back('{tag: 2'd1, data: 32'h40400000, due: cyc + int'(MUL_LAT) + 2});
      last_gnt = 1;
      prev_hs  = 1'b1;
      prev_a   = 32'h3FC00000;
      prev_b   = 32'h40000000;
      @(negedge clk);
      cyc++;
    end
    lat = 99;
    for (int i = 0; i < 10; i++) begin
      step('0, 1'b1);
      if (obs_rv && lat == 99) begin
        lat = cyc - 1 - t0;
        check_eq("t1_tag", 64'(obs_tag), 64'(1));
        check_eq("t1_data", 64'(obs_data), 64'(32'h40400000));
      end
    end
    check_eq("t1_latency", 64'(lat), 64'(MUL_LAT + 2));

    // Continuous traffic from all requesters, consumer always ready.
    for (int i = 0; i < 40; i++) step(all_v, 1'b1);

    // Consumer stalled: exactly RSP_DEPTH handshakes, then release.
    for (int i = 0; i < 20; i++) step('0, 1'b1);
    hs0 = obs_hs;
    for (int i = 0; i < 12; i++) step(all_v, 1'b0);
    check_eq("stall_hs", 64'(obs_hs - hs0), 64'(RSP_DEPTH));
    for (int i = 0; i < 20; i++) step(all_v, 1'b1);
    for (int i = 0; i < 15; i++) step(all_v, 1'($urandom_range(0, 1)));

    // Random traffic and back-pressure.
    for (int i = 0; i < 400; i++)
      step(NUM_REQ'($urandom), ($urandom_range(0, 9) < 7));

`ifdef FMUL_SCHED_STATS_EN
    check_eq("issue_cnt", 64'(issue_cnt), 64'(mdl_issue));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(mdl_stall));
`endif

    // Reset with three ops in flight and consumer stalled.
    for (int i = 0; i < 20; i++) step('0, 1'b1);
    for (int i = 0; i < 3; i++) step(all_v, 1'b0);
    do_reset();
    step(all_v, 1'b1);
    check_eq("post_rst_grant", 64'(obs_ready), 64'(4'b0001));
    for (int i = 0; i < 12; i++) step('0, 1'b1);

    for (int i = 0; i < 200; i++)
      step(NUM_REQ'($urandom), ($urandom_range(0, 9) < 5));
    for (int i = 0; i < 20; i++) step('0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
